// File: rtl/loader_pkg.sv
// Shared definitions for the serial memory loader: FSM states, frame sync byte
// and the default inter-byte timeout.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_RUN,
    ST_ERR
  } state_t;

  localparam logic [7:0] SYNC_BYTE       = 8'hA5;
  localparam int         DEFAULT_TIMEOUT = 1000000;

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog: counts clocks without a received byte while enabled and
// flags expiry once the count reaches TIMEOUT.
module loader_timeout
  import loader_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Count idle clocks; any byte or leaving the frame states restarts the count,
  // and the count holds once it has reached the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!enable || kick) begin
      count <= '0;
    end else if (count != CW'(TIMEOUT)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == CW'(TIMEOUT));

endmodule

// File: rtl/mem_loader.sv
// Frame-based program loader: parses A5 | LEN_LO LEN_HI | 4*N data | CSUM,
// writes the words into instruction memory and releases the core when the
// checksum matches.
module mem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset_n,
  output logic              done,
  output logic              error
);

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

  state_t            state, state_nxt;
  logic [7:0]        csum;
  logic [7:0]        len_lo;
  logic [15:0]       remaining;
  logic [1:0]        idx;
  logic [23:0]       shift;
  logic [ADDR_W-1:0] wr_addr;
  logic              sync_hit;
  logic [15:0]       len_word;
  logic              too_big;
  logic              in_frame;
  logic              expired;

  assign sync_hit = rx_valid && (rx_data == SYNC_BYTE);
  assign len_word = {rx_data, len_lo};
  assign too_big  = {16'd0, len_word} > MAX_WORDS;
  assign in_frame = (state == ST_LEN0) || (state == ST_LEN1) ||
                    (state == ST_DATA) || (state == ST_CSUM);

  loader_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (in_frame),
    .kick   (rx_valid),
    .expired(expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: a byte advances the frame, silence past the limit aborts it.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (sync_hit) state_nxt = ST_LEN0;
      end
      ST_LEN0: begin
        if (rx_valid)     state_nxt = ST_LEN1;
        else if (expired) state_nxt = ST_ERR;
      end
      ST_LEN1: begin
        if (rx_valid) begin
          if (len_word == 16'd0) state_nxt = ST_CSUM;
          else if (too_big)      state_nxt = ST_ERR;
          else                   state_nxt = ST_DATA;
        end else if (expired) begin
          state_nxt = ST_ERR;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          if (idx == 2'd3 && remaining == 16'd1) state_nxt = ST_CSUM;
        end else if (expired) begin
          state_nxt = ST_ERR;
        end
      end
      ST_CSUM: begin
        if (rx_valid)     state_nxt = (rx_data == csum) ? ST_RUN : ST_ERR;
        else if (expired) state_nxt = ST_ERR;
      end
      ST_RUN, ST_ERR: begin
        if (sync_hit) state_nxt = ST_LEN0;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: checksum, length, byte assembly and the registered write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum      <= '0;
      len_lo    <= '0;
      remaining <= '0;
      idx       <= '0;
      shift     <= '0;
      wr_addr   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_RUN, ST_ERR: begin
          if (sync_hit) begin
            csum      <= '0;
            idx       <= '0;
            wr_addr   <= '0;
            remaining <= '0;
          end
        end
        ST_LEN0: begin
          if (rx_valid) begin
            len_lo <= rx_data;
            csum   <= csum + rx_data;
          end
        end
        ST_LEN1: begin
          if (rx_valid) begin
            remaining <= len_word;
            csum      <= csum + rx_data;
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            csum <= csum + rx_data;
            idx  <= idx + 2'd1;
            case (idx)
              2'd0: shift[7:0]   <= rx_data;
              2'd1: shift[15:8]  <= rx_data;
              2'd2: shift[23:16] <= rx_data;
              default: begin
                mem_we    <= 1'b1;
                mem_addr  <= wr_addr;
                mem_wdata <= {rx_data, shift};
                wr_addr   <= wr_addr + ADDR_W'(1);
                remaining <= remaining - 16'd1;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  // A sync byte arriving in RUN or ERR drops the status outputs in the same cycle.
  assign cpu_reset_n = (state == ST_RUN) && !sync_hit;
  assign done        = (state == ST_RUN) && !sync_hit;
  assign error       = (state == ST_ERR) && !sync_hit;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: directed frames plus random frames checked
// against a byte-level frame model and a captured write log.
module tb_mem_loader;

  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_reset_n;
  logic              done;
  logic              error;

  int errors = 0;
  int checks = 0;

  logic [31:0] frameWords[$];
  logic [63:0] expWrites[$];
  logic [63:0] gotWrites[$];
  logic [7:0]  fr[$];

  always #5 clk = ~clk;

  mem_loader #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_reset_n(cpu_reset_n),
    .done       (done),
    .error      (error)
  );

  // Log every memory write seen shortly after a rising edge.
  always @(posedge clk) begin
    #1;
    if (mem_we === 1'b1)
      gotWrites.push_back({{(32-ADDR_W){1'b0}}, mem_addr, mem_wdata});
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic sendSync(input bit checkSame);
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    #1;
    if (checkSame) begin
      checkVal("sync_cpu_reset_n", {63'd0, cpu_reset_n}, 64'd0);
      checkVal("sync_done", {63'd0, done}, 64'd0);
      checkVal("sync_error", {63'd0, error}, 64'd0);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic sendBody(input int n, input bit badCsum, input int maxGap);
    logic [15:0] nn;
    logic [7:0]  sum;
    logic [7:0]  b8;
    logic [31:0] w;
    logic [ADDR_W-1:0] a;
    nn  = 16'(n);
    sum = 8'd0;
    sendByte(nn[7:0], int'($urandom_range(maxGap, 0)));
    sum += nn[7:0];
    sendByte(nn[15:8], int'($urandom_range(maxGap, 0)));
    sum += nn[15:8];
    if (n > (1 << ADDR_W)) return;
    for (int i = 0; i < n; i++) begin
      w = frameWords[i];
      a = ADDR_W'(i);
      expWrites.push_back({{(32-ADDR_W){1'b0}}, a, w});
      for (int k = 0; k < 4; k++) begin
        b8 = w[8*k +: 8];
        sendByte(b8, int'($urandom_range(maxGap, 0)));
        sum += b8;
      end
    end
    sendByte(badCsum ? sum + 8'd1 : sum, 0);
  endtask

  task automatic checkOutput(input string tag, input bit expectRun);
    repeat (2) @(negedge clk);
    checkVal({tag, "_nwrites"}, 64'(gotWrites.size()), 64'(expWrites.size()));
    for (int i = 0; i < expWrites.size(); i++)
      if (i < gotWrites.size()) checkVal({tag, "_write"}, gotWrites[i], expWrites[i]);
    checkVal({tag, "_done"}, {63'd0, done}, {63'd0, expectRun});
    checkVal({tag, "_cpu_reset_n"}, {63'd0, cpu_reset_n}, {63'd0, expectRun});
    checkVal({tag, "_error"}, {63'd0, error}, {63'd0, !expectRun});
    gotWrites.delete();
    expWrites.delete();
  endtask

  task automatic randomWords(input int n);
    frameWords.delete();
    for (int i = 0; i < n; i++) frameWords.push_back($urandom);
  endtask

  task automatic applyStimulus(input string tag, input int n, input bit badCsum,
                               input int maxGap, input bit checkSame);
    randomWords(n);
    sendSync(checkSame);
    sendBody(n, badCsum, maxGap);
    checkOutput(tag, !badCsum && (n <= (1 << ADDR_W)));
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    checkVal("rst_mem_we", {63'd0, mem_we}, 64'd0);
    checkVal("rst_mem_addr", 64'(mem_addr), 64'd0);
    checkVal("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    checkVal("rst_cpu_reset_n", {63'd0, cpu_reset_n}, 64'd0);
    checkVal("rst_done", {63'd0, done}, 64'd0);
    checkVal("rst_error", {63'd0, error}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Known two-word image with a correct checksum, including write timing.
    fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
           8'h93, 8'h00, 8'h10, 8'h00, 8'hB8};
    expWrites.push_back(64'h0000_0000_0000_0013);
    expWrites.push_back(64'h0000_0001_0010_0093);
    sendSync(1'b0);
    for (int i = 0; i < fr.size(); i++) begin
      sendByte(fr[i], 0);
      if (i == 5) begin
        checkVal("wr_timing_we", {63'd0, mem_we}, 64'd1);
        checkVal("wr_timing_addr", 64'(mem_addr), 64'd0);
        checkVal("wr_timing_data", 64'(mem_wdata), 64'h13);
      end
      if (i == 6) checkVal("wr_pulse_width", {63'd0, mem_we}, 64'd0);
    end
    checkOutput("good_frame", 1'b1);

    // Same image with a wrong checksum, started from RUN.
    fr[10] = 8'h00;
    expWrites.push_back(64'h0000_0000_0000_0013);
    expWrites.push_back(64'h0000_0001_0010_0093);
    sendSync(1'b1);
    for (int i = 0; i < fr.size(); i++) sendByte(fr[i], 0);
    checkOutput("bad_csum", 1'b0);

    // Empty image from ERR.
    applyStimulus("empty", 0, 1'b0, 0, 1'b0);

    // Reload from RUN with new contents.
    applyStimulus("reload", 3, 1'b0, 2, 1'b1);

    // Largest image that fits, then one word too many.
    applyStimulus("full", 1 << ADDR_W, 1'b0, 0, 1'b0);
    applyStimulus("oversize", (1 << ADDR_W) + 1, 1'b0, 0, 1'b0);

    // Stall inside a frame.
    sendSync(1'b0);
    sendByte(8'h01, 0);
    sendByte(8'h00, 0);
    sendByte(8'h11, 0);
    repeat (15) @(negedge clk);
    checkVal("timeout_early", {63'd0, error}, 64'd0);
    repeat (3) @(negedge clk);
    checkVal("timeout_error", {63'd0, error}, 64'd1);
    checkVal("timeout_done", {63'd0, done}, 64'd0);
    checkVal("timeout_cpu_reset_n", {63'd0, cpu_reset_n}, 64'd0);
    checkVal("timeout_nwrites", 64'(gotWrites.size()), 64'd0);
    gotWrites.delete();

    // Reset in the middle of a word, then stray bytes in IDLE.
    sendSync(1'b0);
    sendByte(8'h02, 0);
    sendByte(8'h00, 0);
    sendByte(8'h13, 0);
    sendByte(8'h00, 0);
    rst_n = 1'b0;
    #1;
    checkVal("midrst_mem_we", {63'd0, mem_we}, 64'd0);
    checkVal("midrst_mem_addr", 64'(mem_addr), 64'd0);
    checkVal("midrst_mem_wdata", 64'(mem_wdata), 64'd0);
    checkVal("midrst_cpu_reset_n", {63'd0, cpu_reset_n}, 64'd0);
    checkVal("midrst_done", {63'd0, done}, 64'd0);
    checkVal("midrst_error", {63'd0, error}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sendByte(8'h00, 1);
    sendByte(8'hFF, 1);
    repeat (4) @(negedge clk);
    checkVal("stray_done", {63'd0, done}, 64'd0);
    checkVal("stray_error", {63'd0, error}, 64'd0);
    checkVal("stray_cpu_reset_n", {63'd0, cpu_reset_n}, 64'd0);
    checkVal("stray_nwrites", 64'(gotWrites.size()), 64'd0);
    gotWrites.delete();
    applyStimulus("after_reset", 2, 1'b0, 1, 1'b0);

    // Random frames with random gaps and occasional checksum corruption.
    for (int f = 0; f < 10; f++)
      applyStimulus("random", int'($urandom_range(5, 0)), ($urandom_range(3, 0) == 0), 3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
